// File: rtl/store_writer_if.sv
// Store request / memory write bundle between the core, the store writer and data memory.
// Request side: req_valid/req_ready handshake carrying byte address, right-aligned data, funct3.
// Memory side: mem_valid/mem_ready handshake carrying word address, lane data, byte enables.
interface store_writer_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic [2:0]  req_f3;

   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_byte_enable_mask;

   // master: core + memory environment driving the store writer
   modport master (
      output req_valid, req_addr, req_data, req_f3, mem_ready,
      input  req_ready, mem_valid, mem_addr, mem_wdata, mem_byte_enable_mask
   );

   // slave: the store writer itself
   modport slave (
      input  req_valid, req_addr, req_data, req_f3, mem_ready,
      output req_ready, mem_valid, mem_addr, mem_wdata, mem_byte_enable_mask
   );
endinterface

// File: rtl/store_writer.sv
// Purpose: formats core stores into byte lanes, rejects bad ones, buffers legal ones in order.
// Latency: legal store accepted at edge N is on mem_* after edge N when the buffer was empty.
// Backpressure: req_ready = !full (registered occupancy only); head held stable while !mem_ready.
// Ports: clk, rst_n (async active-low); bus (store_writer_if.slave: req_* in, mem_* out);
//        misaligned / illegal one-cycle reject pulses; count = buffer occupancy.
module store_writer #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   store_writer_if.slave            bus,
   output logic                     misaligned,
   output logic                     illegal,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } entry_t;

   entry_t          store_q [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;

   entry_t          fmt;
   entry_t          head;
   logic [1:0]      off;
   logic            is_ill;
   logic            is_mis;
   logic            accept;
   logic            push;
   logic            pop;

   // Classification and lane formatting of the presented request.
   // is_mis is only ever set for a legal funct3, so illegal wins by construction.
   always_comb begin
      off       = bus.req_addr[1:0];
      fmt       = '0;
      fmt.addr  = {bus.req_addr[31:2], 2'b00};
      is_ill    = 1'b0;
      is_mis    = 1'b0;
      unique case (bus.req_f3)
         3'b000: begin
            fmt.wdata = {4{bus.req_data[7:0]}};
            fmt.be    = 4'b0001 << off;
         end
         3'b001: begin
            fmt.wdata = {2{bus.req_data[15:0]}};
            fmt.be    = 4'b0011 << off;
            is_mis    = off[0];
         end
         3'b010: begin
            fmt.wdata = bus.req_data;
            fmt.be    = 4'b1111;
            is_mis    = (off != 2'b00);
         end
         default: is_ill = 1'b1;
      endcase
   end

   // Ready comes from registered occupancy only: no path from req_valid or mem_ready.
   assign bus.req_ready = (count != CW'(DEPTH));
   assign bus.mem_valid = (count != '0);

   assign accept = bus.req_valid && bus.req_ready;
   assign push   = accept && !is_ill && !is_mis;
   assign pop    = bus.mem_valid && bus.mem_ready;

   // Head is gated to zero while empty so stale storage never shows on the bus.
   assign head                     = store_q[rd_ptr];
   assign bus.mem_addr             = bus.mem_valid ? head.addr  : '0;
   assign bus.mem_wdata            = bus.mem_valid ? head.wdata : '0;
   assign bus.mem_byte_enable_mask = bus.mem_valid ? head.be    : '0;

   // Entry storage carries no reset: visibility is governed entirely by count.
   always_ff @(posedge clk) begin
      if (push) begin
         store_q[wr_ptr] <= fmt;
      end
   end

   // Pointers are PW bits wide and DEPTH is a power of two, so they wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         misaligned <= 1'b0;
         illegal    <= 1'b0;
      end else begin
         misaligned <= accept && is_mis;
         illegal    <= accept && is_ill;
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule
